stat_rd_seq: RTL and testbench

- Reader end of the 4x8 AES status register store.
- Drives the store's read address, samples its combinational read data, and streams the bytes out on an 8-bit valid/ready byte channel.
- Sits between the status store and the host/bus byte interface in the AES CBC decrypt path.
- One start pulse produces one burst of NBYTES bytes in ascending address order.

---
 rtl/stat_pkg.sv | 30 +++
 rtl/stat_rd_seq.sv | 122 ++++++++++++
 tb/tb_stat_rd_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/stat_pkg.sv
// Shared definitions for the AES status-store reader: store geometry and FSM state encoding.
// STAT_RD_PARITY_EN adds the PAR state, which needs a third state bit.
package stat_pkg;

  localparam int STAT_NBYTES = 4;
  localparam int STAT_AW     = 2;

`ifdef STAT_RD_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_SEND = 3'b010,
    ST_FIN  = 3'b011,
    ST_PAR  = 3'b100
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_SEND = 2'b10,
    ST_FIN  = 2'b11
  } state_e;
`endif

  // Folds one more sampled byte into the running burst parity.
  function automatic logic [7:0] par_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/stat_rd_seq.sv
// Reader end of the 4x8 AES status store: one start pulse streams NBYTES bytes out on a valid/ready channel.
// With STAT_RD_PARITY_EN defined, a trailing XOR-parity byte follows the data bytes.
module stat_rd_seq
  import stat_pkg::*;
#(
  parameter int NBYTES = STAT_NBYTES,
  parameter int AW     = STAT_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  output logic [AW-1:0] ar,
  input  logic [7:0]    din,
  output logic          busy,
  output logic          done,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(NBYTES);
  localparam logic [AW:0] IDX_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] IDX_ONE  = {{AW{1'b0}}, 1'b1};

  state_e      state_q;
  logic [AW:0] rd_idx_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic        done_q;
`ifdef STAT_RD_PARITY_EN
  logic [7:0]  acc_q;
`endif
  logic        hs_s;

  // rd_idx_q always points at the next byte to fetch, so ar shows it while a byte is stalled.
  assign ar       = rd_idx_q[AW-1:0];
  assign hs_s     = tx_valid_q & tx_ready;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Burst sequencer with the registered byte channel and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rd_idx_q   <= IDX_ZERO;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef STAT_RD_PARITY_EN
      acc_q      <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rd_idx_q <= IDX_ZERO;
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
`ifdef STAT_RD_PARITY_EN
            acc_q   <= 8'h00;
`endif
          end
        end
        ST_LOAD: begin
          tx_data_q  <= din;
          tx_valid_q <= 1'b1;
          rd_idx_q   <= rd_idx_q + IDX_ONE;
          state_q    <= ST_SEND;
`ifdef STAT_RD_PARITY_EN
          acc_q      <= par_fold(acc_q, din);
`endif
        end
        ST_SEND: begin
          if (hs_s) begin
            if (rd_idx_q == LAST_IDX) begin
`ifdef STAT_RD_PARITY_EN
              tx_data_q  <= acc_q;
              state_q    <= ST_PAR;
`else
              tx_valid_q <= 1'b0;
              state_q    <= ST_FIN;
`endif
            end else begin
              tx_data_q <= din;
              rd_idx_q  <= rd_idx_q + IDX_ONE;
`ifdef STAT_RD_PARITY_EN
              acc_q     <= par_fold(acc_q, din);
`endif
            end
          end
        end
`ifdef STAT_RD_PARITY_EN
        ST_PAR: begin
          if (hs_s) begin
            tx_valid_q <= 1'b0;
            state_q    <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          tx_valid_q <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          rd_idx_q   <= IDX_ZERO;
          state_q    <= ST_IDLE;
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          rd_idx_q   <= IDX_ZERO;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stat_rd_seq.sv
// Scoreboard bench for stat_rd_seq: a model of the status store feeds din, expected bytes are queued
// per burst and a negedge monitor checks every handshake. Define STAT_RD_PARITY_EN to test the parity byte.
module tb_stat_rd_seq;

  localparam int NB = 4;
`ifdef STAT_RD_PARITY_EN
  localparam int PEX = 1;
`else
  localparam int PEX = 0;
`endif

  logic       clk;
  logic       rstn;
  logic       start;
  logic [1:0] ar;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  logic [7:0] mem [NB];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int exp_done = 0;

  stat_rd_seq #(.NBYTES(NB), .AW(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .ar(ar), .din(din),
    .busy(busy), .done(done), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  assign din = mem[ar];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [1:0] prev_ar;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    prev_ar    = 2'd0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (done === 1'b1) done_cnt++;
        if (prev_stall && tx_valid === 1'b1) begin
          check("stall_data_stable", {24'd0, tx_data}, {24'd0, prev_data});
          check("stall_ar_stable", {30'd0, ar}, {30'd0, prev_ar});
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", {24'd0, tx_data}, {24'd0, e});
          end
        end
        prev_stall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
        prev_data  = tx_data;
        prev_ar    = ar;
      end
    end
  end

  // Queues the bytes the spec promises for one burst. Mode 3 writes d3 and d0 while byte 1 is
  // stalled: addresses 2..3 are not fetched yet and see the new data, 0..1 were already sampled.
  task automatic push_expected(input int mode);
    logic [7:0] par;
    logic [7:0] b;
    par = 8'h00;
    for (int i = 0; i < NB; i++) begin
      b = mem[i];
      if (mode == 3 && i == 3) b = 8'hA5;
      exp_q.push_back(b);
      par = par ^ b;
    end
    if (PEX == 1) exp_q.push_back(par);
  endtask

  // mode 0: ready high; 1: fixed ready pattern; 2: random ready/start; 3: mid-burst write; 4: start hammered
  task automatic run_burst(input int mode);
    int k;
    logic [6:0] pat;
    pat = 7'b1101001;  // bit k = ready at cycle k: 1,0,0,1,0,1,1
    push_expected(mode);
    start    = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      if (mode == 0 && k == 0) begin
        check("load_no_valid", {31'd0, tx_valid}, 32'd0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
      end
      if (mode == 0 && k == 1) begin
        check("first_valid", {31'd0, tx_valid}, 32'd1);
        check("first_byte", {24'd0, tx_data}, {24'd0, mem[0]});
      end
      case (mode)
        1:       tx_ready = (k < 7) ? pat[k] : 1'b1;
        2:       tx_ready = ($urandom_range(0, 3) != 0);
        3:       tx_ready = !(k == 2 || k == 3);
        default: tx_ready = 1'b1;
      endcase
      case (mode)
        2:       start = ($urandom_range(0, 1) == 1);
        4:       start = busy;
        default: start = 1'b0;
      endcase
      if (mode == 3 && k == 2) begin
        mem[3] = 8'hA5;
        mem[0] = 8'h5A;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    if (mode == 0) check("done_latency", k, NB + 2 + PEX);
    exp_done++;
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
    check("done_count", done_cnt, exp_done);
    exp_q.delete();
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ar", {30'd0, ar}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_burst(0);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    run_burst(1);
    run_burst(4);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_second_burst", {31'd0, tx_valid | busy}, 32'd0);
    end
    run_burst(3);

    // Reset in the middle of SEND aborts the burst with no done pulse.
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    push_expected(0);
    start = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    #1;
    check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ar", {30'd0, ar}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("abort_no_done", done_cnt, exp_done);
    run_burst(0);

    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
      run_burst(2);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
